hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Central pipeline sequencer for the RV32IM 5-stage core. Owns the stage enables and flushes: load-use stalls, branch flushes, and multi-cycle MUL/DIV holds. Drives the operand-forwarding selects for both EX operands from the EX/MEM and MEM/WB destination registers. Sits beside the ID/EX stage and feeds the PC, the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX operand muxes.

Parameters:
MD_TIMEOUT, 40, max cycles waited for MD_DONE before declaring an error (>=2)
CNT_W, 32, width of the stall performance counter

Ports:
CLK  in  1  core clock
RESET  in  1  asynchronous, active-high reset
ID_RS1  in  5  rs1 of instruction in ID
ID_RS2  in  5  rs2 of instruction in ID
ID_USE_RS1  in  1  ID instruction reads rs1
ID_USE_RS2  in  1  ID instruction reads rs2
EX_RS1  in  5  rs1 of instruction in EX
EX_RS2  in  5  rs2 of instruction in EX
EX_RD  in  5  rd of instruction in EX
EX_MEM_READ  in  1  EX instruction is a load
EX_MD_MULTI  in  1  EX instruction is a multi-cycle M-op (DIV/DIVU/REM/REMU/MUL*)
EX_BRANCH_TAKEN  in  1  EX resolved a taken branch or jump
MEM_RD  in  5  rd in EX/MEM
MEM_REG_WRITE  in  1  EX/MEM writes a register
WB_RD  in  5  rd in MEM/WB
WB_REG_WRITE  in  1  MEM/WB writes a register
MD_DONE  in  1  MUL/DIV unit result valid (single-cycle pulse)
PC_EN  out  1  PC update enable
IFID_EN  out  1  IF/ID load enable
IDEX_EN  out  1  ID/EX load enable
IFID_FLUSH  out  1  clear IF/ID to NOP
IDEX_FLUSH  out  1  load bubble into ID/EX
EXMEM_BUBBLE  out  1  load bubble into EX/MEM
MD_START  out  1  one-cycle start pulse to MUL/DIV unit
FWD_A  out  2  operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
FWD_B  out  2  operand B select, same encoding
MD_ERR  out  1  sticky MUL/DIV timeout flag
STALL_CNT  out  CNT_W  cycles in which PC_EN was low (saturating)

Behaviour:
- Reset (async, while RESET high): state=RUN, timeout counter=0, MD_ERR=0, STALL_CNT=0. Outputs forced: PC_EN=IFID_EN=IDEX_EN=0, IFID_FLUSH=IDEX_FLUSH=1, EXMEM_BUBBLE=0, MD_START=0, FWD_A=FWD_B=00.
- FSM states: RUN, MD_WAIT. Registered state; control outputs are combinational decodes of state and inputs.
- RUN, default: all enables 1, flushes/bubble/MD_START 0.
- RUN priority, highest first:
  - (1) EX_BRANCH_TAKEN: IFID_FLUSH=1, IDEX_FLUSH=1, enables stay 1. Stay in RUN.
  - (2) EX_MD_MULTI: MD_START=1, PC_EN=IFID_EN=IDEX_EN=0, EXMEM_BUBBLE=1. Go to MD_WAIT and clear the counter.
  - (3) Load-use: EX_MEM_READ and EX_RD!=0 and ((ID_USE_RS1 and ID_RS1==EX_RD) or (ID_USE_RS2 and ID_RS2==EX_RD)). Drive PC_EN=IFID_EN=0 and IDEX_FLUSH=1 for exactly one cycle. Stay in RUN.
- Branch together with MD_MULTI is illegal; branch wins and MD_START stays 0.
- MD_WAIT:
  - PC_EN=IFID_EN=IDEX_EN=0, EXMEM_BUBBLE=1, MD_START=0. The counter increments each cycle.
  - On MD_DONE: EXMEM_BUBBLE=0, all enables 1 in that same cycle. Next state RUN. MD_DONE arriving in the cycle of MD_START is ignored.
  - If the counter reaches MD_TIMEOUT-1 without MD_DONE: set MD_ERR (sticky until reset), release as if done, go to RUN.
  - EX_BRANCH_TAKEN and load-use are ignored in MD_WAIT.
- Forwarding (combinational, every state):
  - FWD_A=01 if MEM_REG_WRITE and MEM_RD!=0 and MEM_RD==EX_RS1.
  - Else FWD_A=10 if WB_REG_WRITE and WB_RD!=0 and WB_RD==EX_RS1.
  - Else FWD_A=00.
  - FWD_B is the same using EX_RS2.
  - EX/MEM beats MEM/WB; x0 is never forwarded.
- STALL_CNT increments in any non-reset cycle with PC_EN=0 and saturates at all-ones.

Decomposition:
- Shared package holds the FWD_* encodings (FWD_REG=00, FWD_EXMEM=01, FWD_MEMWB=10) and the state encodings (ST_RUN, ST_MD_WAIT).
- One sub-module, operand_forward_sel: one 5-bit source register in, 2-bit select out. Instantiated twice, for A and B.

Test Plan:
- Load x5 in EX, ID uses rs1=x5 -> one cycle of PC_EN=0, IFID_EN=0, IDEX_FLUSH=1; next cycle all enables 1; STALL_CNT=1.
- Load with EX_RD=0, ID_RS1=0 -> no stall; EX/MEM and MEM/WB both rd=x7 with EX_RS1=EX_RS2=7 -> FWD_A=FWD_B=01.
- DIV in EX, MD_DONE 34 cycles after MD_START -> MD_START high 1 cycle, stall lasts 35 cycles including the release cycle, MD_ERR=0, STALL_CNT=34.
- MD_DONE never arrives with MD_TIMEOUT=40 -> release after 40 MD_WAIT cycles, MD_ERR=1 and stays 1.
- Taken branch in EX together with a load-use condition -> IFID_FLUSH=IDEX_FLUSH=1, PC_EN=1, no stall.
- RESET asserted mid-MD_WAIT -> immediate forced reset outputs; after release state=RUN, STALL_CNT=0, MD_ERR=0.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the pipeline hazard/sequencing logic.
// Forwarding select codes and the sequencer FSM states.
package hazard_control_unit_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_control_unit_operand_forward_sel.sv
// Forwarding select for one EX operand: EX/MEM result beats MEM/WB, x0 never forwarded.
module operand_forward_sel
  import hazard_control_unit_pkg::*;
(
  input  logic [4:0] src_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src_rs))
      sel = FWD_EXMEM;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src_rs))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stage enables/flushes for load-use, branches and multi-cycle
// MUL/DIV, operand forwarding selects, MUL/DIV timeout flag and a stall counter.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [4:0]       EX_RS1,
  input  logic [4:0]       EX_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MEM_READ,
  input  logic             EX_MD_MULTI,
  input  logic             EX_BRANCH_TAKEN,
  input  logic [4:0]       MEM_RD,
  input  logic             MEM_REG_WRITE,
  input  logic [4:0]       WB_RD,
  input  logic             WB_REG_WRITE,
  input  logic             MD_DONE,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IDEX_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             EXMEM_BUBBLE,
  output logic             MD_START,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             MD_ERR,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MD_TIMEOUT - 1);

  state_t        state, state_next;
  logic [TW-1:0] md_cnt;
  logic          cnt_clr, cnt_inc, set_err;
  logic          load_use, md_timeout;
  logic [1:0]    fwd_a_sel, fwd_b_sel;

  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                    ((ID_USE_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USE_RS2 && (ID_RS2 == EX_RD)));
  assign md_timeout = (md_cnt == TIMEOUT_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_RUN;
      md_cnt    <= '0;
      MD_ERR    <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      state <= state_next;
      if (cnt_clr)
        md_cnt <= '0;
      else if (cnt_inc)
        md_cnt <= md_cnt + TW'(1);
      if (set_err)
        MD_ERR <= 1'b1;
      if (!PC_EN && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

  // Branch outranks the M-op start; load-use only matters when neither is present.
  always_comb begin
    state_next   = state;
    PC_EN        = 1'b1;
    IFID_EN      = 1'b1;
    IDEX_EN      = 1'b1;
    IFID_FLUSH   = 1'b0;
    IDEX_FLUSH   = 1'b0;
    EXMEM_BUBBLE = 1'b0;
    MD_START     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    set_err      = 1'b0;
    if (RESET) begin
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IDEX_EN    = 1'b0;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (EX_BRANCH_TAKEN) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else if (EX_MD_MULTI) begin
            MD_START     = 1'b1;
            PC_EN        = 1'b0;
            IFID_EN      = 1'b0;
            IDEX_EN      = 1'b0;
            EXMEM_BUBBLE = 1'b1;
            cnt_clr      = 1'b1;
            state_next   = ST_MD_WAIT;
          end else if (load_use) begin
            PC_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IDEX_FLUSH = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          cnt_inc = 1'b1;
          if (MD_DONE || md_timeout) begin
            set_err    = !MD_DONE;
            state_next = ST_RUN;
          end else begin
            PC_EN        = 1'b0;
            IFID_EN      = 1'b0;
            IDEX_EN      = 1'b0;
            EXMEM_BUBBLE = 1'b1;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  operand_forward_sel u_fwd_a (
    .src_rs        (EX_RS1),
    .mem_rd        (MEM_RD),
    .mem_reg_write (MEM_REG_WRITE),
    .wb_rd         (WB_RD),
    .wb_reg_write  (WB_REG_WRITE),
    .sel           (fwd_a_sel)
  );

  operand_forward_sel u_fwd_b (
    .src_rs        (EX_RS2),
    .mem_rd        (MEM_RD),
    .mem_reg_write (MEM_REG_WRITE),
    .wb_rd         (WB_RD),
    .wb_reg_write  (WB_REG_WRITE),
    .sel           (fwd_b_sel)
  );

  assign FWD_A = RESET ? FWD_REG : fwd_a_sel;
  assign FWD_B = RESET ? FWD_REG : fwd_b_sel;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit with hand-computed expectations.
module tb_hazard_control_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ID_RS1, ID_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD;
  logic        ID_USE_RS1, ID_USE_RS2, EX_MEM_READ, EX_MD_MULTI, EX_BRANCH_TAKEN;
  logic        MEM_REG_WRITE, WB_REG_WRITE, MD_DONE;
  logic        PC_EN, IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH, EXMEM_BUBBLE, MD_START;
  logic [1:0]  FWD_A, FWD_B;
  logic        MD_ERR;
  logic [31:0] STALL_CNT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
    .EX_MD_MULTI(EX_MD_MULTI), .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
    .MEM_RD(MEM_RD), .MEM_REG_WRITE(MEM_REG_WRITE), .WB_RD(WB_RD), .WB_REG_WRITE(WB_REG_WRITE),
    .MD_DONE(MD_DONE),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IDEX_EN(IDEX_EN), .IFID_FLUSH(IFID_FLUSH),
    .IDEX_FLUSH(IDEX_FLUSH), .EXMEM_BUBBLE(EXMEM_BUBBLE), .MD_START(MD_START),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .MD_ERR(MD_ERR), .STALL_CNT(STALL_CNT)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge before touching inputs.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    ID_RS1 = 0; ID_RS2 = 0; ID_USE_RS1 = 0; ID_USE_RS2 = 0;
    EX_RS1 = 0; EX_RS2 = 0; EX_RD = 0; EX_MEM_READ = 0; EX_MD_MULTI = 0;
    EX_BRANCH_TAKEN = 0; MEM_RD = 0; MEM_REG_WRITE = 0; WB_RD = 0; WB_REG_WRITE = 0;
    MD_DONE = 0;
  endtask

  initial begin
    int n;
    int stall_seen;
    int start_seen;
    clearInputs();
    RESET = 1'b1;
    MEM_REG_WRITE = 1; MEM_RD = 7; EX_RS1 = 7;
    #3;
    checkOutput("rst_pc_en", PC_EN, 0);
    checkOutput("rst_ifid_en", IFID_EN, 0);
    checkOutput("rst_idex_en", IDEX_EN, 0);
    checkOutput("rst_ifid_flush", IFID_FLUSH, 1);
    checkOutput("rst_idex_flush", IDEX_FLUSH, 1);
    checkOutput("rst_bubble", EXMEM_BUBBLE, 0);
    checkOutput("rst_md_start", MD_START, 0);
    checkOutput("rst_fwd_a", FWD_A, 0);
    checkOutput("rst_stall_cnt", STALL_CNT, 0);
    checkOutput("rst_md_err", MD_ERR, 0);

    applyStimulus(2);
    clearInputs();
    RESET = 1'b0;
    EX_MEM_READ = 1; EX_RD = 5; ID_USE_RS1 = 1; ID_RS1 = 5;
    #1;
    checkOutput("lu_pc_en", PC_EN, 0);
    checkOutput("lu_ifid_en", IFID_EN, 0);
    checkOutput("lu_idex_flush", IDEX_FLUSH, 1);
    checkOutput("lu_idex_en", IDEX_EN, 1);
    checkOutput("lu_md_start", MD_START, 0);
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("lu_after_pc_en", PC_EN, 1);
    checkOutput("lu_after_ifid_en", IFID_EN, 1);
    checkOutput("lu_after_idex_flush", IDEX_FLUSH, 0);
    checkOutput("lu_stall_cnt", STALL_CNT, 1);

    EX_MEM_READ = 1; EX_RD = 9; ID_USE_RS2 = 1; ID_RS2 = 9; ID_RS1 = 3;
    #1;
    checkOutput("lu_rs2_pc_en", PC_EN, 0);
    ID_USE_RS2 = 0;
    #1;
    checkOutput("lu_rs2_unused_pc_en", PC_EN, 1);
    clearInputs();
    EX_MEM_READ = 1; EX_RD = 0; ID_USE_RS1 = 1; ID_RS1 = 0;
    #1;
    checkOutput("lu_x0_pc_en", PC_EN, 1);

    MEM_REG_WRITE = 1; MEM_RD = 7; WB_REG_WRITE = 1; WB_RD = 7; EX_RS1 = 7; EX_RS2 = 7;
    #1;
    checkOutput("fwd_both_a", FWD_A, 1);
    checkOutput("fwd_both_b", FWD_B, 1);
    MEM_REG_WRITE = 0;
    #1;
    checkOutput("fwd_wb_a", FWD_A, 2);
    checkOutput("fwd_wb_b", FWD_B, 2);
    MEM_REG_WRITE = 1; MEM_RD = 0; EX_RS1 = 0; WB_RD = 0; WB_REG_WRITE = 1;
    #1;
    checkOutput("fwd_x0_a", FWD_A, 0);
    EX_RS1 = 3; EX_RS2 = 9; MEM_RD = 3; WB_RD = 9;
    #1;
    checkOutput("fwd_split_a", FWD_A, 1);
    checkOutput("fwd_split_b", FWD_B, 2);
    WB_REG_WRITE = 0;
    #1;
    checkOutput("fwd_nowrite_b", FWD_B, 0);
    clearInputs();

    EX_BRANCH_TAKEN = 1; EX_MEM_READ = 1; EX_RD = 5; ID_USE_RS1 = 1; ID_RS1 = 5;
    #1;
    checkOutput("br_ifid_flush", IFID_FLUSH, 1);
    checkOutput("br_idex_flush", IDEX_FLUSH, 1);
    checkOutput("br_pc_en", PC_EN, 1);
    checkOutput("br_ifid_en", IFID_EN, 1);
    EX_MD_MULTI = 1;
    #1;
    checkOutput("br_md_start", MD_START, 0);
    checkOutput("br_md_bubble", EXMEM_BUBBLE, 0);
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("br_stall_cnt", STALL_CNT, 1);

    RESET = 1'b1;
    applyStimulus(1);
    RESET = 1'b0;
    EX_MD_MULTI = 1;
    #1;
    checkOutput("div_md_start", MD_START, 1);
    checkOutput("div_pc_en", PC_EN, 0);
    checkOutput("div_bubble", EXMEM_BUBBLE, 1);
    stall_seen = 1;
    start_seen = 1;
    for (int i = 1; i <= 34; i++) begin
      applyStimulus(1);
      MD_DONE = (i == 34);
      EX_BRANCH_TAKEN = (i == 10);
      #1;
      if (i == 10) checkOutput("div_ignore_branch", IFID_FLUSH, 0);
      if (!PC_EN) stall_seen++;
      if (MD_START) start_seen++;
    end
    checkOutput("div_release_pc_en", PC_EN, 1);
    checkOutput("div_release_idex_en", IDEX_EN, 1);
    checkOutput("div_release_bubble", EXMEM_BUBBLE, 0);
    checkOutput("div_stall_cycles", stall_seen, 34);
    checkOutput("div_start_pulses", start_seen, 1);
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("div_stall_cnt", STALL_CNT, 34);
    checkOutput("div_md_err", MD_ERR, 0);
    checkOutput("div_run_pc_en", PC_EN, 1);

    EX_MD_MULTI = 1;
    applyStimulus(1);
    n = 1;
    while (!PC_EN && n < 60) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("to_wait_cycles", n, 40);
    checkOutput("to_err_before_edge", MD_ERR, 0);
    applyStimulus(1);
    clearInputs();
    #1;
    checkOutput("to_md_err", MD_ERR, 1);
    checkOutput("to_stall_cnt", STALL_CNT, 74);
    applyStimulus(5);
    checkOutput("to_md_err_sticky", MD_ERR, 1);
    checkOutput("to_run_pc_en", PC_EN, 1);

    EX_MD_MULTI = 1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(3);
    checkOutput("mid_wait_pc_en", PC_EN, 0);
    RESET = 1'b1;
    #1;
    checkOutput("mid_rst_ifid_flush", IFID_FLUSH, 1);
    checkOutput("mid_rst_idex_flush", IDEX_FLUSH, 1);
    checkOutput("mid_rst_bubble", EXMEM_BUBBLE, 0);
    checkOutput("mid_rst_stall_cnt", STALL_CNT, 0);
    checkOutput("mid_rst_md_err", MD_ERR, 0);
    applyStimulus(1);
    RESET = 1'b0;
    #1;
    checkOutput("post_rst_pc_en", PC_EN, 1);
    checkOutput("post_rst_bubble", EXMEM_BUBBLE, 0);
    applyStimulus(1);
    checkOutput("post_rst_stall_cnt", STALL_CNT, 0);
    checkOutput("post_rst_md_err", MD_ERR, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
